// File: rtl/mul_pipe.sv
// -----------------------------------------------------------------------------
// mul_pipe -- two-stage pipelined radix-4 Booth multiplier for the EXE/MEM path.
//
// Stage S1 registers the carry-save (sum, carry) pair from the Booth
// partial-product reduction. Stage S2 registers the final 2*WIDTH product
// after the carry-propagate add. Each stage has a valid/ready handshake, so
// the block accepts one operation per cycle while the consumer keeps up.
//
// Parameters:
//   WIDTH  operand width (even, >= 8)
//   TAG_W  width of the pass-through writeback tag
//
// Ports:
//   mul_clk      clock
//   reset        synchronous, active-high reset
//   flush        synchronous cancel of every in-flight operation
//   in_valid     operation offered         in_ready    operation can be taken
//   in_op        00 MUL, 01 MULH, 10 MULHU, 11 treated as MUL
//   in_x, in_y   multiplicand, multiplier  in_tag      writeback tag
//   out_valid    result available          out_ready   consumer takes result
//   out_result   low or high half, selected by op
//   out_product  full 2*WIDTH product      out_tag     tag of the result
//
// Optional feature (macro MUL_ACC_EN): adds in_acc / in_acc_en, captured at
// accept. The selected accumulator is added modulo 2^(2*WIDTH) as one more
// carry-save row, so latency is unchanged.
// -----------------------------------------------------------------------------
module mul_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                 mul_clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  input  logic [TAG_W-1:0]     in_tag,
`ifdef MUL_ACC_EN
  input  logic [2*WIDTH-1:0]   in_acc,
  input  logic                 in_acc_en,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int PW  = 2 * WIDTH;     // product width
  localparam int EW  = WIDTH + 2;     // extended operand width
  localparam int NPP = EW / 2;        // number of Booth partial products

  // ---------------------------------------------------------------------------
  // Booth encoding and carry-save reduction feeding S1
  // ---------------------------------------------------------------------------
  logic          sgn;
  logic [EW-1:0] x_ext;
  logic [EW:0]   y_booth;    // multiplier with the implicit y[-1] = 0 appended
  logic [PW-1:0] x_wide;
  logic [PW-1:0] pp;
  logic [PW-1:0] csa_s;
  logic [PW-1:0] csa_c;
  logic [PW-1:0] csa_t;

  // NOTE: always_comb uses blocking assignments so each loop iteration sees
  // the running sum/carry produced by the previous one.
  always_comb begin
    sgn     = (in_op == 2'b01);
    x_ext   = {{2{sgn & in_x[WIDTH-1]}}, in_x};
    y_booth = {{2{sgn & in_y[WIDTH-1]}}, in_y, 1'b0};
    x_wide  = {{(PW-EW){x_ext[EW-1]}}, x_ext};
    csa_s   = '0;
    csa_c   = '0;
    csa_t   = '0;
    pp      = '0;
    for (int i = 0; i < NPP; i++) begin
      case (y_booth[2*i +: 3])
        3'b001, 3'b010: pp = x_wide;
        3'b011:         pp = x_wide << 1;
        3'b100:         pp = -(x_wide << 1);
        3'b101, 3'b110: pp = -x_wide;
        default:        pp = '0;
      endcase
      pp    = pp << (2 * i);
      // 3:2 compressor; the carry is weighted one bit higher and any bit
      // pushed past the product width is dropped (arithmetic is mod 2^PW).
      csa_t = csa_s ^ csa_c ^ pp;
      csa_c = ((csa_s & csa_c) | (csa_s & pp) | (csa_c & pp)) << 1;
      csa_s = csa_t;
    end
`ifdef MUL_ACC_EN
    pp    = in_acc_en ? in_acc : '0;
    csa_t = csa_s ^ csa_c ^ pp;
    csa_c = ((csa_s & csa_c) | (csa_s & pp) | (csa_c & pp)) << 1;
    csa_s = csa_t;
`endif
  end

  // ---------------------------------------------------------------------------
  // Pipeline control and next-state logic
  // ---------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [PW-1:0]    s1_sum_q,   s1_sum_d;
  logic [PW-1:0]    s1_carry_q, s1_carry_d;
  logic [1:0]       s1_op_q,    s1_op_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [PW-1:0]    s2_prod_q,  s2_prod_d;
  logic [1:0]       s2_op_q,    s2_op_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

  logic s2_adv;
  logic accept;
  logic s2_hi;

  // in_ready looks only at pipeline state and out_ready, never at in_valid.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !flush && (!s1_valid_q || s2_adv);
  assign accept   = in_valid && in_ready;

  // NOTE: every signal gets a hold default before the conditional updates,
  // so no path leaves a _d value unassigned and no latch is inferred.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_carry_d = s1_carry_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_op_d    = s2_op_q;
    s2_tag_d   = s2_tag_q;

    // S1 -> S2 moves whenever S2 frees up; an S2 output transfer and a new
    // S1 load in the same cycle is the normal full-throughput case.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_d = s1_sum_q + s1_carry_q;
        s2_op_d   = s1_op_q;
        s2_tag_d  = s1_tag_q;
      end
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_sum_d   = csa_s;
      s1_carry_d = csa_c;
      s1_op_d    = in_op;
      s1_tag_d   = in_tag;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled at the same edge.
  always_ff @(posedge mul_clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_op_q    <= 2'b00;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
      s2_op_q    <= s2_op_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  // NOTE: S1 datapath flops carry no reset; they are only read while
  // s1_valid_q is set, which does get reset.
  always_ff @(posedge mul_clk) begin
    s1_sum_q   <= s1_sum_d;
    s1_carry_q <= s1_carry_d;
    s1_op_q    <= s1_op_d;
    s1_tag_q   <= s1_tag_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs straight from S2
  // ---------------------------------------------------------------------------
  assign s2_hi       = (s2_op_q == 2'b01) || (s2_op_q == 2'b10);
  assign out_valid   = s2_valid_q;
  assign out_product = s2_prod_q;
  assign out_tag     = s2_tag_q;
  assign out_result  = s2_hi ? s2_prod_q[PW-1:WIDTH] : s2_prod_q[WIDTH-1:0];

endmodule
